reg_block_xfer: RTL and testbench
=================================

# reg_block_xfer

Multi-register transfer sequencer for the CPU register file: on a single `start` it walks a register mask and moves each selected register to or from memory, one register per memory beat. It drives the register file's read ports, write port and post-increment count inputs directly, using port b as the auto-incrementing base/address register. It is the engine behind block load/store and push/pop instructions.

## Interface
- `SEL_WIDTH`, 8, register select width; must match the register file.
- `COUNT_WIDTH`, 8, register file count input width.
- `MASK_WIDTH`, 16, number of registers addressable by the mask; register i is selected by mask bit i, and `MASK_WIDTH` ≤ 2**`SEL_WIDTH`.

Ports:
- `clk` in 1: clock; all state changes on its posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a transfer; sampled only in IDLE.
- `dir` in 1: 0 = store (register → memory), 1 = load (memory → register); latched at start.
- `mask` in MASK_WIDTH: registers to transfer; latched at start.
- `base_sel` in SEL_WIDTH: register holding the memory address; latched at start.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `mem_req` out 1: memory beat request.
- `mem_we` out 1: beat is a write (store).
- `mem_ack` in 1: memory accepts/returns the current beat.
- `oe_a`, `sel_a` out 1/SEL_WIDTH: data register read (store).
- `oe_b`, `sel_b` out 1/SEL_WIDTH: base register read (address bus).
- `count_a`, `count_b` out COUNT_WIDTH: register file post-increments.
- `ld`, `sel_in` out 1/SEL_WIDTH: register file write (load).

## Operation
- States: IDLE, XFER, DONE.
- IDLE + `start`: latch `dir` and `base_sel`. Latch `mask` with the bit at `base_sel` forced to 0; the base register is never transferred.
  - Latched mask nonzero → XFER.
  - Latched mask zero → DONE; no memory beats are issued.
- XFER: current register `cur` is the lowest set bit of the remaining mask (ascending order).
  - Always drive `mem_req`=1, `oe_b`=1, `sel_b`=`base_sel`, `mem_we`=~dir.
  - Store: `oe_a`=1, `sel_a`=`cur`.
  - Load: `sel_in`=`cur`, and `ld`=`mem_ack`.
  - On `mem_ack`: `count_b`=1, clear `cur` from the remaining mask. If the remaining mask is now empty → DONE, else stay in XFER.
  - Without `mem_ack`: hold all outputs stable and keep `count_b`=0.
- DONE: `done`=1 for exactly one cycle → IDLE.
- `count_a` is always 0.
- `busy`=1 in XFER and DONE, else 0.
- `start` while not in IDLE is ignored.

## Timing
- Reset (async assert): state IDLE; every output 0 immediately. Mid-transfer reset abandons the transfer; no `done` pulse.
- `mem_req`, `mem_we`, `oe_*`, `sel_*` decode from registered state only. `mem_ack` combinationally affects only `ld`, `count_b` and next state. There is no path from `mem_ack` to `mem_req`.
- Latency with zero-wait ack: `start` sampled at edge 0; beats k=1..N occupy cycles 1..N; `done` in cycle N+1; IDLE in cycle N+2.
- Each wait cycle without `mem_ack` adds one cycle.
- Empty mask: `done` in cycle 1.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after `done`.

## Configuration
- `REG_XFER_ABORT_EN` defined:
  - Adds input `abort` (1) and output `aborted` (1).
  - `abort`=1 in XFER forces IDLE at the next edge. On that edge the beat is not completed, `count_b` is 0 and `ld` is 0 even if `mem_ack`=1.
  - `aborted` pulses 1 cycle; `done` is not pulsed. `abort` is ignored in IDLE and DONE.
- Macro undefined: neither port exists; a transfer always runs to completion.

## Test plan
- Store, `mask`=0x0005, `base_sel`=13, `mem_ack` tied 1 → two beats: `sel_a`=0 then 2, each with `count_b`=1, `mem_we`=1; `done` in cycle 3.
- Load, `mask`=0x8001, ack delayed 2 cycles per beat → `mem_req` held stable; `ld`=1 only on the ack cycles with `sel_in`=0 then 15; `done` in cycle 7.
- `mask`=0x2004, `base_sel`=13 → only register 2 transferred; one beat.
- `mask`=0 → no `mem_req`; `done` in cycle 1; `busy`=1 for one cycle.
- `rst_n` low during the second beat of a 3-register load → all outputs 0 asynchronously; no `done`; a fresh `start` after release works normally.
- With `REG_XFER_ABORT_EN`: `abort` and `mem_ack` together on beat 1 → no `ld`, `count_b`=0, `aborted` pulse, IDLE next cycle.

Source files
------------

// File: rtl/reg_block_xfer.sv
// Multi-register transfer sequencer: walks a register mask and moves one register per memory beat.
// Optional abort support is enabled with `define REG_XFER_ABORT_EN.
module reg_block_xfer #(
  parameter int SEL_WIDTH   = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int MASK_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dir,
  input  logic [MASK_WIDTH-1:0]  mask,
  input  logic [SEL_WIDTH-1:0]   base_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_req,
  output logic                   mem_we,
  input  logic                   mem_ack,
  output logic                   oe_a,
  output logic [SEL_WIDTH-1:0]   sel_a,
  output logic                   oe_b,
  output logic [SEL_WIDTH-1:0]   sel_b,
  output logic [COUNT_WIDTH-1:0] count_a,
  output logic [COUNT_WIDTH-1:0] count_b,
  output logic                   ld,
  output logic [SEL_WIDTH-1:0]   sel_in
`ifdef REG_XFER_ABORT_EN
  ,
  input  logic                   abort,
  output logic                   aborted
`endif
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                state, next_state;
  logic                  dir_q;
  logic [SEL_WIDTH-1:0]  base_q;
  logic [MASK_WIDTH-1:0] mask_q;
  logic [MASK_WIDTH-1:0] start_mask;
  logic [MASK_WIDTH-1:0] cur_bit;
  logic [MASK_WIDTH-1:0] mask_left;
  logic [SEL_WIDTH-1:0]  cur;
  logic                  abort_now;
  logic                  beat_done;

`ifdef REG_XFER_ABORT_EN
  logic aborted_q;
  assign abort_now = abort && (state == XFER);
  assign aborted   = aborted_q;
`else
  assign abort_now = 1'b0;
`endif

  assign beat_done = (state == XFER) && mem_ack && !abort_now;
  assign cur_bit   = mask_q & (~mask_q + MASK_WIDTH'(1));
  assign mask_left = mask_q & ~cur_bit;
  assign count_a   = '0;

  // The base register supplies the address, so it is never itself transferred.
  always_comb begin
    start_mask = mask;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (SEL_WIDTH'(i) == base_sel) start_mask[i] = 1'b0;
    end
  end

  always_comb begin
    cur = '0;
    for (int i = MASK_WIDTH - 1; i >= 0; i--) begin
      if (mask_q[i]) cur = SEL_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q  <= 1'b0;
      base_q <= '0;
      mask_q <= '0;
    end else if (state == IDLE && start) begin
      dir_q  <= dir;
      base_q <= base_sel;
      mask_q <= start_mask;
    end else if (beat_done) begin
      mask_q <= mask_left;
    end
  end

`ifdef REG_XFER_ABORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted_q <= 1'b0;
    else        aborted_q <= abort_now;
  end
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (start_mask != '0) ? XFER : DONE;
      XFER: begin
        if (abort_now)                         next_state = IDLE;
        else if (mem_ack && mask_left == '0)   next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Only ld and count_b see mem_ack; the request side decodes from registered state.
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    mem_req = 1'b0;
    mem_we  = 1'b0;
    oe_a    = 1'b0;
    sel_a   = '0;
    oe_b    = 1'b0;
    sel_b   = '0;
    count_b = '0;
    ld      = 1'b0;
    sel_in  = '0;
    if (state == XFER) begin
      mem_req = 1'b1;
      mem_we  = ~dir_q;
      oe_b    = 1'b1;
      sel_b   = base_q;
      count_b = beat_done ? COUNT_WIDTH'(1) : '0;
      if (dir_q) begin
        sel_in = cur;
        ld     = beat_done;
      end else begin
        oe_a  = 1'b1;
        sel_a = cur;
      end
    end
  end

endmodule

// File: tb/tb_reg_block_xfer.sv
// Directed self-checking bench for reg_block_xfer; outputs sampled just after the falling edge.
module tb_reg_block_xfer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, dir, mem_ack;
  logic [15:0] mask;
  logic [7:0]  base_sel;
  logic        busy, done, mem_req, mem_we, oe_a, oe_b, ld;
  logic [7:0]  sel_a, sel_b, sel_in, count_a, count_b;
`ifdef REG_XFER_ABORT_EN
  logic        abort, aborted;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_block_xfer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .mask(mask),
    .base_sel(base_sel), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_ack(mem_ack), .oe_a(oe_a), .sel_a(sel_a),
    .oe_b(oe_b), .sel_b(sel_b), .count_a(count_a), .count_b(count_b),
    .ld(ld), .sel_in(sel_in)
`ifdef REG_XFER_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the falling edge of cycle 1 (start sampled at edge 0).
  task automatic applyStimulus(input logic d, input logic [15:0] m, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; dir = d; mask = m; base_sel = b;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  logic       ack_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] sel_tab [6] = '{8'd0, 8'd0, 8'd0, 8'd15, 8'd15, 8'd15};

  initial begin
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; mem_ack = 1'b0; mask = '0; base_sel = '0;
`ifdef REG_XFER_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_req", mem_req, 0);
    checkOutput("reset_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] store mask=0x0005 base=13");
    mem_ack = 1'b1;
    applyStimulus(1'b0, 16'h0005, 8'd13);
    checkOutput("st_c1_req", mem_req, 1);
    checkOutput("st_c1_we", mem_we, 1);
    checkOutput("st_c1_oea", oe_a, 1);
    checkOutput("st_c1_sela", sel_a, 0);
    checkOutput("st_c1_selb", sel_b, 13);
    checkOutput("st_c1_oeb", oe_b, 1);
    checkOutput("st_c1_cntb", count_b, 1);
    checkOutput("st_c1_cnta", count_a, 0);
    checkOutput("st_c1_ld", ld, 0);
    nextCycle();
    checkOutput("st_c2_sela", sel_a, 2);
    checkOutput("st_c2_cntb", count_b, 1);
    nextCycle();
    checkOutput("st_c3_done", done, 1);
    checkOutput("st_c3_req", mem_req, 0);
    checkOutput("st_c3_busy", busy, 1);

    $display("[TB] back-to-back store mask=0x0010 base=0");
    applyStimulus(1'b0, 16'h0010, 8'd0);
    checkOutput("b2b_c1_sela", sel_a, 4);
    checkOutput("b2b_c1_req", mem_req, 1);
    nextCycle();
    checkOutput("b2b_c2_done", done, 1);
    nextCycle();
    checkOutput("b2b_c3_busy", busy, 0);
    checkOutput("b2b_c3_done", done, 0);

    $display("[TB] load mask=0x8001 with two wait cycles per beat");
    mem_ack = 1'b0;
    applyStimulus(1'b1, 16'h8001, 8'd3);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      mem_ack = ack_tab[c];
      #1;
      checkOutput($sformatf("ld_c%0d_req", c + 1), mem_req, 1);
      checkOutput($sformatf("ld_c%0d_we", c + 1), mem_we, 0);
      checkOutput($sformatf("ld_c%0d_selin", c + 1), sel_in, sel_tab[c]);
      checkOutput($sformatf("ld_c%0d_ld", c + 1), ld, ack_tab[c]);
      checkOutput($sformatf("ld_c%0d_cntb", c + 1), count_b, {7'd0, ack_tab[c]});
      checkOutput($sformatf("ld_c%0d_selb", c + 1), sel_b, 3);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checkOutput("ld_c7_done", done, 1);
    nextCycle();

    $display("[TB] store mask=0x2004 base=13 skips the base");
    mem_ack = 1'b1;
    applyStimulus(1'b0, 16'h2004, 8'd13);
    checkOutput("skip_c1_sela", sel_a, 2);
    nextCycle();
    checkOutput("skip_c2_done", done, 1);
    checkOutput("skip_c2_req", mem_req, 0);
    nextCycle();

    $display("[TB] empty mask");
    applyStimulus(1'b0, 16'h0000, 8'd0);
    checkOutput("empty_c1_done", done, 1);
    checkOutput("empty_c1_busy", busy, 1);
    checkOutput("empty_c1_req", mem_req, 0);
    nextCycle();
    checkOutput("empty_c2_busy", busy, 0);

    $display("[TB] reset during second beat of a load");
    applyStimulus(1'b1, 16'h0007, 8'd8);
    checkOutput("rst_c1_selin", sel_in, 0);
    @(negedge clk);
    #2;
    checkOutput("rst_c2_selin", sel_in, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_req", mem_req, 0);
    checkOutput("rst_async_ld", ld, 0);
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_cntb", count_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checkOutput("rst_no_done", done, 0);
    end
    applyStimulus(1'b0, 16'h0003, 8'd4);
    checkOutput("fresh_c1_sela", sel_a, 0);
    nextCycle();
    checkOutput("fresh_c2_sela", sel_a, 1);
    nextCycle();
    checkOutput("fresh_c3_done", done, 1);
    nextCycle();

`ifdef REG_XFER_ABORT_EN
    $display("[TB] abort with ack on first beat");
    applyStimulus(1'b1, 16'h0003, 8'd9);
    abort = 1'b1;
    #1;
    checkOutput("ab_c1_ld", ld, 0);
    checkOutput("ab_c1_cntb", count_b, 0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    checkOutput("ab_c2_aborted", aborted, 1);
    checkOutput("ab_c2_busy", busy, 0);
    checkOutput("ab_c2_done", done, 0);
    nextCycle();
    checkOutput("ab_c3_aborted", aborted, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
